// File: rtl/search_timer.sv
// search_timer
//   Per-move time manager sitting between the UCI front end and the engine
//   coordinator. A go pulse captures the clocks/increments for the side to
//   move, one COMPUTE cycle turns them into a millisecond budget, and RUN
//   counts that budget down against a millisecond prescaler, raising a
//   single-cycle timeout when it expires. Clock, movetime and infinite modes
//   are supported; stop/done abort a run and go restarts it.
//
// Ports
//   clk_in            system clock (clk_game domain)
//   rst_n_in          asynchronous active-low reset
//   go_in             1-cycle start/restart pulse
//   mode_in           0=clock, 1=movetime, 2/3=infinite
//   side_in           0=white to move, 1=black to move
//   wtime_in/btime_in remaining ms per side, signed
//   winc_in/binc_in   increment ms per side, signed
//   movetime_in       fixed budget ms for movetime mode, signed
//   stop_in           abort the run, no timeout pulse
//   done_in           engine finished, ends the run, no timeout pulse
//   active_out        high while a search is being timed
//   timeout_out       1-cycle pulse when the budget expires
//   budget_ms_out     budget latched for the current/last run
//   remaining_ms_out  ms left (0 when idle or infinite)
//   elapsed_ms_out    ms since run start, saturating at all-ones
module search_timer #(
  parameter int CLOCK_FREQ    = 40_000_000,
  parameter int TIME_W        = 32,
  parameter int BUDGET_SHIFT  = 3,
  parameter int OVERHEAD_MS   = 20,
  parameter int MIN_BUDGET_MS = 10
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     go_in,
  input  logic [1:0]               mode_in,
  input  logic                     side_in,
  input  logic signed [TIME_W-1:0] wtime_in,
  input  logic signed [TIME_W-1:0] btime_in,
  input  logic signed [TIME_W-1:0] winc_in,
  input  logic signed [TIME_W-1:0] binc_in,
  input  logic signed [TIME_W-1:0] movetime_in,
  input  logic                     stop_in,
  input  logic                     done_in,
  output logic                     active_out,
  output logic                     timeout_out,
  output logic [TIME_W-1:0]        budget_ms_out,
  output logic [TIME_W-1:0]        remaining_ms_out,
  output logic [TIME_W-1:0]        elapsed_ms_out
);

  localparam int PRESC = CLOCK_FREQ / 1000;
  localparam int PS_W  = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESC - 1);
  localparam logic [TIME_W-1:0] MAX_POS = {1'b0, {(TIME_W-1){1'b1}}};
  localparam logic [TIME_W-1:0] OVH     = TIME_W'(OVERHEAD_MS);
  localparam logic [TIME_W-1:0] MIN_B   = TIME_W'(MIN_BUDGET_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  // Negative clock values from the GUI are treated as "no time".
  function automatic logic [TIME_W-1:0] clamp_neg(input logic signed [TIME_W-1:0] v);
    return v[TIME_W-1] ? '0 : $unsigned(v);
  endfunction

  // Both operands are non-negative, so the sum only needs to saturate at the
  // largest positive signed value.
  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                                input logic [TIME_W-1:0] b);
    logic [TIME_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, MAX_POS}) ? MAX_POS : s[TIME_W-1:0];
  endfunction

  function automatic logic [TIME_W-1:0] floor_min(input logic [TIME_W-1:0] v);
    return (v < MIN_B) ? MIN_B : v;
  endfunction

  function automatic logic [TIME_W-1:0] clock_budget(input logic [TIME_W-1:0] t,
                                                     input logic [TIME_W-1:0] inc);
    logic [TIME_W-1:0] head;
    logic [TIME_W-1:0] tail;
    head = sat_add(inc, t >> BUDGET_SHIFT);
    tail = (t > OVH) ? (t - OVH) : '0;
    return floor_min((head < tail) ? head : tail);
  endfunction

  // Operands captured on go (side already resolved)
  logic [TIME_W-1:0] t_p0;
  logic [TIME_W-1:0] inc_p0;
  logic [TIME_W-1:0] mt_p0;
  logic              mt_mode_p0;
  logic              inf_p0;

  // Budget evaluated during COMPUTE, registered on COMPUTE exit
  logic [TIME_W-1:0] budget_p1;

  logic [PS_W-1:0] presc;

  logic latch_op;
  logic load_run;
  logic abort_run;
  logic count_en;
  logic wrap;
  logic expire;

  always_comb begin
    if (inf_p0)
      budget_p1 = '0;
    else if (mt_mode_p0)
      budget_p1 = floor_min(mt_p0);
    else
      budget_p1 = clock_budget(t_p0, inc_p0);
  end

  // A run expires on the wrap that takes remaining from 1 to 0.
  assign wrap   = (state == S_RUN) && (presc == PS_LAST);
  assign expire = wrap && !inf_p0 && (remaining_ms_out == TIME_W'(1));

  always_comb begin
    state_nxt = state;
    latch_op  = 1'b0;
    load_run  = 1'b0;
    abort_run = 1'b0;
    count_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go_in) begin
          latch_op  = 1'b1;
          state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (go_in) begin
          latch_op  = 1'b1;
          state_nxt = S_COMPUTE;
        end else if (stop_in || done_in) begin
          abort_run = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          load_run  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (go_in) begin
          latch_op  = 1'b1;
          state_nxt = S_COMPUTE;
        end else if (stop_in || done_in) begin
          abort_run = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          count_en = 1'b1;
          if (expire)
            state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // ---- stage p0: operand capture on go ----
  always_ff @(posedge clk_in) begin
    if (latch_op) begin
      t_p0       <= clamp_neg(side_in ? btime_in : wtime_in);
      inc_p0     <= clamp_neg(side_in ? binc_in : winc_in);
      mt_p0      <= clamp_neg(movetime_in);
      mt_mode_p0 <= (mode_in == 2'd1);
      inf_p0     <= mode_in[1];
    end
  end

  // ---- stage p1: budget load and millisecond countdown ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_out       <= 1'b0;
      timeout_out      <= 1'b0;
      budget_ms_out    <= '0;
      remaining_ms_out <= '0;
      elapsed_ms_out   <= '0;
      presc            <= '0;
    end else begin
      timeout_out <= 1'b0;
      if (load_run) begin
        active_out       <= 1'b1;
        budget_ms_out    <= budget_p1;
        remaining_ms_out <= budget_p1;
        elapsed_ms_out   <= '0;
        presc            <= '0;
      end else if (abort_run) begin
        active_out       <= 1'b0;
        remaining_ms_out <= '0;
      end else if (count_en) begin
        if (wrap) begin
          presc <= '0;
          if (elapsed_ms_out != '1)
            elapsed_ms_out <= elapsed_ms_out + TIME_W'(1);
          if (!inf_p0)
            remaining_ms_out <= remaining_ms_out - TIME_W'(1);
          if (expire) begin
            active_out  <= 1'b0;
            timeout_out <= 1'b1;
          end
        end else begin
          presc <= presc + PS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_search_timer.sv
module tb_search_timer;

  localparam int CPM = 8;  // clock cycles per ms at CLOCK_FREQ=8000

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               go = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic               side = 1'b0;
  logic signed [31:0] wtime = '0;
  logic signed [31:0] btime = '0;
  logic signed [31:0] winc = '0;
  logic signed [31:0] binc = '0;
  logic signed [31:0] movetime = '0;
  logic               stop = 1'b0;
  logic               done = 1'b0;
  logic               active;
  logic               timeout;
  logic [31:0]        budget_ms;
  logic [31:0]        remaining_ms;
  logic [31:0]        elapsed_ms;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  search_timer #(
    .CLOCK_FREQ(8000),
    .TIME_W(32),
    .BUDGET_SHIFT(3),
    .OVERHEAD_MS(20),
    .MIN_BUDGET_MS(10)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .go_in(go),
    .mode_in(mode),
    .side_in(side),
    .wtime_in(wtime),
    .btime_in(btime),
    .winc_in(winc),
    .binc_in(binc),
    .movetime_in(movetime),
    .stop_in(stop),
    .done_in(done),
    .active_out(active),
    .timeout_out(timeout),
    .budget_ms_out(budget_ms),
    .remaining_ms_out(remaining_ms),
    .elapsed_ms_out(elapsed_ms)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeout) pulse_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference budget straight from the timing rules.
  function automatic longint model_budget(input int md, input bit sd, input longint w,
                                          input longint b, input longint wi,
                                          input longint bi, input longint mt);
    longint t, inc, a, s, bud;
    if (md >= 2) return 0;
    if (md == 1) begin
      bud = (mt < 0) ? 0 : mt;
    end else begin
      t   = sd ? b : w;
      inc = sd ? bi : wi;
      if (t < 0) t = 0;
      if (inc < 0) inc = 0;
      a = inc + t / 8;
      if (a > 64'sd2147483647) a = 64'sd2147483647;
      s = (t > 20) ? t - 20 : 0;
      bud = (a < s) ? a : s;
    end
    if (bud < 10) bud = 10;
    return bud;
  endfunction

  task automatic start_run(input int md, input bit sd, input int w, input int b,
                           input int wi, input int bi, input int mt,
                           output longint bud);
    @(negedge clk);
    mode = 2'(md); side = sd;
    wtime = w; btime = b; winc = wi; binc = bi; movetime = mt;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    bud = model_budget(md, sd, w, b, wi, bi, mt);
    check_val("active_on", active, 1);
    check_val("budget", budget_ms, bud);
    check_val("remaining_init", remaining_ms, bud);
    check_val("elapsed_init", elapsed_ms, 0);
  endtask

  // Called one negedge after the run entered RUN.
  task automatic run_to_timeout(input longint bud);
    longint k = 0;
    int p0 = pulse_cnt;
    while (!timeout && k < bud * CPM + 16) begin
      @(negedge clk);
      k++;
    end
    check_val("timeout_seen", timeout, 1);
    check_val("timeout_cycle", k, bud * CPM);
    check_val("active_after_to", active, 0);
    check_val("elapsed_at_to", elapsed_ms, bud);
    check_val("remaining_at_to", remaining_ms, 0);
    @(negedge clk);
    check_val("timeout_width", timeout, 0);
    repeat (10) @(negedge clk);
    check_val("timeout_pulses", pulse_cnt - p0, 1);
  endtask

  task automatic abort_at(input int k, input bit use_done, input longint bud);
    int p0 = pulse_cnt;
    repeat (k) @(negedge clk);
    if (use_done) done = 1'b1; else stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; done = 1'b0;
    check_val("active_after_abort", active, 0);
    check_val("remaining_after_abort", remaining_ms, 0);
    check_val("elapsed_after_abort", elapsed_ms, k / CPM);
    check_val("budget_hold", budget_ms, bud);
    repeat (20) @(negedge clk);
    check_val("no_timeout_abort", pulse_cnt - p0, 0);
  endtask

  initial begin
    longint bud;
    int md, w, b, wi, bi, mt, k, p0;
    bit sd;

    // Reset state
    #12;
    check_val("rst_active", active, 0);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_budget", budget_ms, 0);
    check_val("rst_remaining", remaining_ms, 0);
    check_val("rst_elapsed", elapsed_ms, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stop while idle is ignored
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check_val("idle_stop_active", active, 0);

    // Clock mode white: 800/10 -> 110 ms
    start_run(0, 0, 800, 0, 10, 0, 0, bud);
    check_val("t1_budget_const", bud, 110);
    run_to_timeout(bud);

    // Clock mode black, overhead clamp and floor: 10 ms
    start_run(0, 1, 0, 25, 0, 100, 0, bud);
    check_val("t2_budget_const", bud, 10);
    run_to_timeout(bud);

    // Negative operands and movetime floor
    start_run(0, 0, -5, 0, -3, 0, 0, bud);
    abort_at(3, 0, bud);
    start_run(1, 0, 0, 0, 0, 0, 0, bud);
    abort_at(5, 1, bud);
    start_run(1, 0, 0, 0, 0, 0, 50, bud);
    run_to_timeout(bud);

    // Increment sum saturation
    start_run(0, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 0, bud);
    abort_at(5, 0, bud);

    // Stop at ms 40 of a 110 ms run
    start_run(0, 0, 800, 0, 10, 0, 0, bud);
    abort_at(40 * CPM + 2, 0, bud);

    // Stop on the very cycle the timeout would fire
    start_run(1, 0, 0, 0, 0, 0, 12, bud);
    abort_at(12 * CPM - 1, 0, bud);

    // Infinite mode for 10000 cycles, then done
    p0 = pulse_cnt;
    start_run(2, 0, 800, 0, 10, 0, 0, bud);
    repeat (10000) @(negedge clk);
    check_val("inf_no_timeout", pulse_cnt - p0, 0);
    check_val("inf_remaining", remaining_ms, 0);
    check_val("inf_elapsed", elapsed_ms, 1250);
    check_val("inf_active", active, 1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_val("inf_done_active", active, 0);

    // Restart mid-run at ms 30 with movetime 20
    p0 = pulse_cnt;
    start_run(0, 0, 800, 0, 10, 0, 0, bud);
    repeat (30 * CPM + 3) @(negedge clk);
    mode = 2'd1; movetime = 20; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check_val("restart_active", active, 1);
    @(negedge clk);
    check_val("restart_budget", budget_ms, 20);
    check_val("restart_elapsed", elapsed_ms, 0);
    run_to_timeout(20);
    check_val("restart_pulses", pulse_cnt - p0, 1);

    // Randomized runs against the model
    for (int it = 0; it < 25; it++) begin
      md = int'($urandom_range(0, 3));
      sd = 1'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 450)) - 50;
      b  = int'($urandom_range(0, 450)) - 50;
      wi = int'($urandom_range(0, 40)) - 10;
      bi = int'($urandom_range(0, 40)) - 10;
      mt = int'($urandom_range(0, 65)) - 5;
      start_run(md, sd, w, b, wi, bi, mt, bud);
      if (md >= 2) begin
        p0 = pulse_cnt;
        k = int'($urandom_range(8, 300));
        repeat (k) @(negedge clk);
        check_val("rnd_inf_elapsed", elapsed_ms, k / CPM);
        check_val("rnd_inf_no_timeout", pulse_cnt - p0, 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check_val("rnd_inf_done", active, 0);
      end else if ($urandom_range(0, 1) == 0) begin
        run_to_timeout(bud);
      end else begin
        k = int'($urandom_range(1, int'(bud) * CPM - 1));
        abort_at(k, 1'($urandom_range(0, 1)), bud);
      end
    end

    // Asynchronous reset mid-run
    p0 = pulse_cnt;
    start_run(0, 0, 800, 0, 10, 0, 0, bud);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_active", active, 0);
    check_val("arst_budget", budget_ms, 0);
    check_val("arst_remaining", remaining_ms, 0);
    check_val("arst_elapsed", elapsed_ms, 0);
    check_val("arst_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check_val("arst_no_timeout", pulse_cnt - p0, 0);
    check_val("arst_idle", active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
